// File: rtl/mem_loader.sv
// Program-load front end for the processor memory port.
// In LOAD mode, each Load rising edge writes the switch-bank word to the next
// consecutive address. Start hands the memory port to the processor and
// raises Run; a second Start returns to the loader without losing its position.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// ST_LOAD  | loader owns the port, waiting for Load / Clear / Start edges
// ST_WRITE | one-cycle write strobe, then advance pointer and count
// ST_RUN   | processor owns the port, Run held high
module mem_loader #(
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic [15:0]   Entry,
  input  logic          Load,
  input  logic          Start,
  input  logic          Clear,
  input  logic [15:0]   ProcAddress,
  input  logic [15:0]   ProcDOUT,
  input  logic          ProcWrite,
  output logic [AW-1:0] MemAddress,
  output logic [15:0]   MemData,
  output logic          MemWren,
  output logic          Run,
  output logic [AW:0]   Count,
  output logic          Full,
  output logic [1:0]    Mode
);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_WRITE = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  state_t        state, state_nxt;
  logic [AW-1:0] wr_ptr, wr_ptr_nxt;
  logic [AW:0]   count, count_nxt;
  logic [AW-1:0] ld_addr, ld_addr_nxt;
  logic [15:0]   ld_data, ld_data_nxt;
  logic          ld_wren, ld_wren_nxt;
  logic          load_q, start_q;
  logic          load_rise, start_rise;
  logic          full;

  // Upper processor address bits are outside the memory and deliberately dropped.
  logic unused_proc_addr;
  assign unused_proc_addr = ^ProcAddress[15:AW];

  assign load_rise  = Load & ~load_q;
  assign start_rise = Start & ~start_q;
  assign full       = (count == FULL_CNT);

  // State and datapath registers; reset is immediate so a write strobe cannot linger.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state   <= ST_LOAD;
      wr_ptr  <= '0;
      count   <= '0;
      ld_addr <= '0;
      ld_data <= '0;
      ld_wren <= 1'b0;
      load_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      wr_ptr  <= wr_ptr_nxt;
      count   <= count_nxt;
      ld_addr <= ld_addr_nxt;
      ld_data <= ld_data_nxt;
      ld_wren <= ld_wren_nxt;
      load_q  <= Load;
      start_q <= Start;
    end
  end

  // Next-state and datapath updates; a Load edge outranks Clear, which outranks Start.
  always_comb begin
    state_nxt   = state;
    wr_ptr_nxt  = wr_ptr;
    count_nxt   = count;
    ld_addr_nxt = ld_addr;
    ld_data_nxt = ld_data;
    ld_wren_nxt = ld_wren;
    unique case (state)
      ST_LOAD: begin
        if (load_rise) begin
          if (!full) begin
            ld_addr_nxt = wr_ptr;
            ld_data_nxt = Entry;
            ld_wren_nxt = 1'b1;
            state_nxt   = ST_WRITE;
          end
        end else if (Clear) begin
          wr_ptr_nxt = '0;
          count_nxt  = '0;
        end else if (start_rise && count != '0) begin
          state_nxt = ST_RUN;
        end
      end
      ST_WRITE: begin
        ld_wren_nxt = 1'b0;
        wr_ptr_nxt  = wr_ptr + AW'(1);
        count_nxt   = count + (AW+1)'(1);
        state_nxt   = ST_LOAD;
      end
      ST_RUN: begin
        if (start_rise) state_nxt = ST_LOAD;
      end
      default: state_nxt = ST_LOAD;
    endcase
  end

  // Memory port mux: processor drives it directly while running.
  always_comb begin
    if (state == ST_RUN) begin
      MemAddress = ProcAddress[AW-1:0];
      MemData    = ProcDOUT;
      MemWren    = ProcWrite;
    end else begin
      MemAddress = ld_addr;
      MemData    = ld_data;
      MemWren    = ld_wren;
    end
  end

  assign Run   = (state == ST_RUN);
  assign Count = count;
  assign Full  = full;
  assign Mode  = state;

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: a behavioural memory captures writes from the
// port, and each scenario task checks outputs on the falling edge.
module tb_mem_loader;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic [15:0] Entry = '0;
  logic        Load = 1'b0;
  logic        Start = 1'b0;
  logic        Clear = 1'b0;
  logic [15:0] ProcAddress = '0;
  logic [15:0] ProcDOUT = '0;
  logic        ProcWrite = 1'b0;
  logic [4:0]  MemAddress;
  logic [15:0] MemData;
  logic        MemWren;
  logic        Run;
  logic [5:0]  Count;
  logic        Full;
  logic [1:0]  Mode;

  int total = 0;
  int bad   = 0;

  logic [15:0] tb_mem [32];

  mem_loader #(.DEPTH(32), .AW(5)) dut (
    .Clock(Clock), .Resetn(Resetn), .Entry(Entry), .Load(Load), .Start(Start),
    .Clear(Clear), .ProcAddress(ProcAddress), .ProcDOUT(ProcDOUT),
    .ProcWrite(ProcWrite), .MemAddress(MemAddress), .MemData(MemData),
    .MemWren(MemWren), .Run(Run), .Count(Count), .Full(Full), .Mode(Mode)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) if (MemWren) tb_mem[MemAddress] <= MemData;

  task automatic load_pulse(input logic [15:0] e);
    @(negedge Clock); Entry = e; Load = 1'b1;
    @(negedge Clock); Load = 1'b0;
    @(negedge Clock);
  endtask

  task automatic do_clear();
    @(negedge Clock); Clear = 1'b1;
    @(negedge Clock); Clear = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 32; i++) tb_mem[i] = 16'hDEAD;
    Resetn = 1'b0;
    #3;
    total++; if (Mode !== 2'd0)  begin bad++; $display("FAIL reset_mode got=%0d exp=0", Mode); end
    total++; if (Count !== 6'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", Count); end
    total++; if (Full !== 1'b0 || Run !== 1'b0 || MemWren !== 1'b0)
      begin bad++; $display("FAIL reset_flags got full=%b run=%b wren=%b exp=0,0,0", Full, Run, MemWren); end
    total++; if (MemAddress !== 5'd0 || MemData !== 16'd0)
      begin bad++; $display("FAIL reset_port got addr=%0d data=%h exp=0,0000", MemAddress, MemData); end
    @(negedge Clock); Resetn = 1'b1;
    @(negedge Clock);
  endtask

  task automatic test_three_loads();
    logic [15:0] words [3];
    words[0] = 16'h0283; words[1] = 16'h0041; words[2] = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock); Entry = words[i]; Load = 1'b1;
      @(negedge Clock);
      total++; if (MemWren !== 1'b1 || MemAddress !== 5'(i))
        begin bad++; $display("FAIL load3_strobe%0d got wren=%b addr=%0d exp=1,%0d", i, MemWren, MemAddress, i); end
      Load = 1'b0;
      @(negedge Clock);
      total++; if (MemWren !== 1'b0)
        begin bad++; $display("FAIL load3_drop%0d got wren=%b exp=0", i, MemWren); end
    end
    total++; if (Count !== 6'd3) begin bad++; $display("FAIL load3_count got=%0d exp=3", Count); end
    for (int i = 0; i < 3; i++) begin
      total++; if (tb_mem[i] !== words[i])
        begin bad++; $display("FAIL load3_mem%0d got=%h exp=%h", i, tb_mem[i], words[i]); end
    end
  endtask

  task automatic test_held_load();
    int writes = 0;
    logic [4:0] waddr = '0;
    @(negedge Clock); Entry = 16'hABCD; Load = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      if (MemWren === 1'b1) begin writes++; waddr = MemAddress; end
    end
    Load = 1'b0;
    @(negedge Clock);
    total++; if (writes != 1) begin bad++; $display("FAIL held_writes got=%0d exp=1", writes); end
    total++; if (waddr !== 5'd3) begin bad++; $display("FAIL held_addr got=%0d exp=3", waddr); end
    total++; if (Count !== 6'd4) begin bad++; $display("FAIL held_count got=%0d exp=4", Count); end
    total++; if (tb_mem[3] !== 16'hABCD) begin bad++; $display("FAIL held_mem got=%h exp=abcd", tb_mem[3]); end
  endtask

  task automatic test_full();
    int writes = 0;
    do_clear();
    total++; if (Count !== 6'd0) begin bad++; $display("FAIL clear_count got=%0d exp=0", Count); end
    for (int i = 0; i < 32; i++) load_pulse(16'h1000 + 16'(i));
    total++; if (Full !== 1'b1 || Count !== 6'd32)
      begin bad++; $display("FAIL full_after32 got full=%b count=%0d exp=1,32", Full, Count); end
    total++; if (tb_mem[31] !== 16'h101F) begin bad++; $display("FAIL full_mem31 got=%h exp=101f", tb_mem[31]); end
    @(negedge Clock); Entry = 16'hFFFF; Load = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      if (MemWren === 1'b1) writes++;
    end
    Load = 1'b0;
    @(negedge Clock);
    total++; if (writes != 0) begin bad++; $display("FAIL full_33rd_writes got=%0d exp=0", writes); end
    total++; if (tb_mem[0] !== 16'h1000) begin bad++; $display("FAIL full_mem0 got=%h exp=1000", tb_mem[0]); end
    total++; if (Count !== 6'd32) begin bad++; $display("FAIL full_count got=%0d exp=32", Count); end
  endtask

  task automatic test_load_start_same();
    do_clear();
    load_pulse(16'h2000);
    load_pulse(16'h2001);
    @(negedge Clock); Entry = 16'h2002; Load = 1'b1; Start = 1'b1;
    @(negedge Clock);
    total++; if (Mode !== 2'd1 || MemWren !== 1'b1 || Run !== 1'b0)
      begin bad++; $display("FAIL same_edge_write got mode=%0d wren=%b run=%b exp=1,1,0", Mode, MemWren, Run); end
    Load = 1'b0; Start = 1'b0;
    @(negedge Clock);
    total++; if (Mode !== 2'd0 || Run !== 1'b0 || Count !== 6'd3)
      begin bad++; $display("FAIL same_edge_after got mode=%0d run=%b count=%0d exp=0,0,3", Mode, Run, Count); end
    ProcAddress = 16'hFFE7; Start = 1'b1;
    @(negedge Clock);
    total++; if (Run !== 1'b1 || Mode !== 2'd2 || MemAddress !== 5'h07)
      begin bad++; $display("FAIL start_run got run=%b mode=%0d addr=%h exp=1,2,07", Run, Mode, MemAddress); end
    Start = 1'b0;
  endtask

  task automatic test_run_port();
    @(negedge Clock);
    ProcWrite = 1'b1; ProcAddress = 16'h0010; ProcDOUT = 16'h1234;
    #1;
    total++; if (MemWren !== 1'b1 || MemAddress !== 5'd16 || MemData !== 16'h1234)
      begin bad++; $display("FAIL run_port got wren=%b addr=%0d data=%h exp=1,16,1234", MemWren, MemAddress, MemData); end
    @(negedge Clock); ProcWrite = 1'b0;
    total++; if (tb_mem[16] !== 16'h1234) begin bad++; $display("FAIL run_mem16 got=%h exp=1234", tb_mem[16]); end
    Load = 1'b1; Clear = 1'b1;
    @(negedge Clock);
    total++; if (Mode !== 2'd2 || Count !== 6'd3)
      begin bad++; $display("FAIL run_ignore got mode=%0d count=%0d exp=2,3", Mode, Count); end
    Load = 1'b0; Clear = 1'b0; Start = 1'b1;
    @(negedge Clock);
    total++; if (Mode !== 2'd0 || Run !== 1'b0 || Count !== 6'd3 || MemAddress !== 5'd2)
      begin bad++; $display("FAIL run_exit got mode=%0d run=%b count=%0d addr=%0d exp=0,0,3,2", Mode, Run, Count, MemAddress); end
    Start = 1'b0;
  endtask

  task automatic test_clear_start();
    do_clear();
    total++; if (Count !== 6'd0) begin bad++; $display("FAIL clear2_count got=%0d exp=0", Count); end
    Start = 1'b1;
    @(negedge Clock);
    total++; if (Mode !== 2'd0 || Run !== 1'b0)
      begin bad++; $display("FAIL start_empty got mode=%0d run=%b exp=0,0", Mode, Run); end
    Start = 1'b0;
    @(negedge Clock);
  endtask

  task automatic test_async_reset();
    load_pulse(16'h5555);
    @(negedge Clock); Entry = 16'h6666; Load = 1'b1;
    @(negedge Clock);
    total++; if (MemWren !== 1'b1) begin bad++; $display("FAIL pre_reset_wren got=%b exp=1", MemWren); end
    #2 Resetn = 1'b0;
    #1;
    total++; if (MemWren !== 1'b0 || Mode !== 2'd0 || Count !== 6'd0)
      begin bad++; $display("FAIL reset_write got wren=%b mode=%0d count=%0d exp=0,0,0", MemWren, Mode, Count); end
    Load = 1'b0;
    @(negedge Clock); Resetn = 1'b1;
    load_pulse(16'h7777);
    ProcAddress = 16'h0007;
    @(negedge Clock); Start = 1'b1;
    @(negedge Clock); Start = 1'b0;
    total++; if (Run !== 1'b1) begin bad++; $display("FAIL pre_reset_run got=%b exp=1", Run); end
    #2 Resetn = 1'b0;
    #1;
    total++; if (Run !== 1'b0 || MemAddress !== 5'd0)
      begin bad++; $display("FAIL reset_run got run=%b addr=%0d exp=0,0", Run, MemAddress); end
    @(negedge Clock); Resetn = 1'b1;
    @(negedge Clock);
  endtask

  initial begin
    test_reset();
    test_three_loads();
    test_held_load();
    test_full();
    test_load_start_same();
    test_run_port();
    test_clear_start();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
